fetch_stage: RTL

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register. It sits directly upstream of the ID stage and consumes `PcWrite` and `IF_ID_write` from hazard detection, plus branch redirects resolved in ID. It holds, bubbles or flushes IF/ID accordingly.

---
 rtl/pipeline_pkg.sv | 23 ++
 rtl/fetch_perf_counters.sv | 34 +++
 rtl/fetch_stage.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants: fetch FSM states, the canonical NOP,
// and opcode values also used by hazard detection.
package pipeline_pkg;

  typedef enum logic [1:0] {
    S_RESET,
    S_REQ,
    S_HAVE,
    S_DROP
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Word-aligned PC increment; wraps naturally at 32 bits.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return (pc + 32'd4) & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Three free-running 32-bit event counters for the fetch stage
// (stalls, wait-state bubbles, redirect flushes). Wrap on overflow.
module fetch_perf_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_evt,
  input  logic        bubble_evt,
  input  logic        flush_evt,
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt,
  output logic [31:0] flush_cnt
);

  logic [2:0] evt;
  assign evt = {flush_evt, bubble_evt, stall_evt};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      logic [31:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (evt[gi]) begin
          cnt_reg <= cnt_reg + 32'd1;
        end
      end
    end
  endgenerate

  assign stall_cnt  = g_cnt[0].cnt_reg;
  assign bubble_cnt = g_cnt[1].cnt_reg;
  assign flush_cnt  = g_cnt[2].cnt_reg;

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC, instruction-memory request FSM and IF/ID register.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PcWrite,
  input  logic        IF_ID_write,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] IF_ID_instr,
  output logic [31:0] IF_ID_pc4,
  output logic        IF_ID_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'd3;

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  drop_addr_reg, drop_addr_next;
  logic [31:0]  hold_reg, hold_next;
  logic [31:0]  instr_reg, instr_next;
  logic [31:0]  pc4_reg, pc4_next;
  logic         valid_reg, valid_next;
  logic [31:0]  pc4;
  logic [31:0]  redirect_aligned;

  assign pc4              = pc_plus4(pc_reg);
  assign redirect_aligned = redirect_pc & ~32'd3;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_RESET;
      pc_reg        <= RESET_PC_ALIGNED;
      drop_addr_reg <= '0;
      hold_reg      <= '0;
      instr_reg     <= NOP_INSTR;
      pc4_reg       <= '0;
      valid_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      drop_addr_reg <= drop_addr_next;
      hold_reg      <= hold_next;
      instr_reg     <= instr_next;
      pc4_reg       <= pc4_next;
      valid_reg     <= valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    drop_addr_next = drop_addr_reg;
    hold_next      = hold_reg;
    instr_next     = instr_reg;
    pc4_next       = pc4_reg;
    valid_next     = valid_reg;
    imem_req       = 1'b0;
    imem_addr      = pc_reg;

    case (state_reg)
      S_RESET: begin
        state_next = S_REQ;
        if (redirect_valid) begin
          pc_next    = redirect_aligned;
          instr_next = NOP_INSTR;
          pc4_next   = pc4;
          valid_next = 1'b0;
        end
      end

      S_REQ: begin
        imem_req = 1'b1;
        if (redirect_valid) begin
          pc_next    = redirect_aligned;
          instr_next = NOP_INSTR;
          pc4_next   = pc4;
          valid_next = 1'b0;
          hold_next  = '0;
          // An unanswered request must still be retired at its old address.
          if (!imem_valid) begin
            drop_addr_next = pc_reg;
            state_next     = S_DROP;
          end
        end else if (imem_valid) begin
          if (IF_ID_write) begin
            instr_next = imem_rdata;
            pc4_next   = pc4;
            valid_next = 1'b1;
            if (PcWrite) pc_next = pc4;
          end else begin
            hold_next  = imem_rdata;
            state_next = S_HAVE;
          end
        end else if (IF_ID_write) begin
          instr_next = NOP_INSTR;
          pc4_next   = pc4;
          valid_next = 1'b0;
        end
      end

      S_HAVE: begin
        if (redirect_valid) begin
          pc_next    = redirect_aligned;
          instr_next = NOP_INSTR;
          pc4_next   = pc4;
          valid_next = 1'b0;
          hold_next  = '0;
          state_next = S_REQ;
        end else if (IF_ID_write) begin
          instr_next = hold_reg;
          pc4_next   = pc4;
          valid_next = 1'b1;
          if (PcWrite) pc_next = pc4;
          state_next = S_REQ;
        end
      end

      S_DROP: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr_reg;
        if (redirect_valid) begin
          pc_next    = redirect_aligned;
          instr_next = NOP_INSTR;
          pc4_next   = pc4;
          valid_next = 1'b0;
        end else begin
          if (IF_ID_write) begin
            instr_next = NOP_INSTR;
            pc4_next   = pc4;
            valid_next = 1'b0;
          end
          if (imem_valid) state_next = S_REQ;
        end
      end

      default: state_next = S_RESET;
    endcase
  end

  assign IF_ID_instr = instr_reg;
  assign IF_ID_pc4   = pc4_reg;
  assign IF_ID_valid = valid_reg;

`ifdef FETCH_PERF_CNT_EN
  logic bubble_event;
  assign bubble_event = (state_reg == S_REQ) && !redirect_valid && !imem_valid && IF_ID_write;

  fetch_perf_counters u_perf (
    .clk        (clk),
    .reset      (reset),
    .stall_evt  (!IF_ID_write),
    .bubble_evt (bubble_event),
    .flush_evt  (redirect_valid),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt)
  );
`endif

endmodule
